// File: rtl/serial_equality_pkg.sv
// ============================================================================
// Module      : serial_equality_pkg
// Description : Shared state encodings and counter-width helper for the
//               bit-serial magnitude/equality comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_equality_pkg;

    // Comparator FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must hold 0..bits, so it needs clog2(bits+1) bits
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_equality_bit_counter.sv
// ============================================================================
// Module      : bit_counter
// Description : Loadable up-counter with synchronous clear, count enable and
//               a terminal-count flag raised when the count equals BITS-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_counter
    import serial_equality_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load,
    input  logic [cnt_width(BITS)-1:0] load_value,
    input  logic                       enable,
    output logic                       terminal
);

    localparam int                 W    = cnt_width(BITS);
    localparam logic [W-1:0]       LAST = W'(BITS - 1);

    logic [W-1:0] count;

    // Clear has priority over load, load over increment
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/serial_equality.sv
// ============================================================================
// Module      : serial_equality
// Description : Bit-serial comparator. Takes operands A/B one bit per beat,
//               MSB first, and after BITS beats reports eq / gt / lt.
//               Optional macro SERIAL_EQUALITY_EARLY_EXIT_EN: finish on the
//               first mismatching beat instead of consuming all BITS beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_equality
    import serial_equality_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

`ifdef SERIAL_EQUALITY_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam int W = cnt_width(BITS);

    state_t state;
    logic   decided;
    logic   sign;

    // A beat arriving together with start is discarded (restart wins)
    logic accept;
    logic mismatch;
    logic last_beat;
    logic next_decided;
    logic next_sign;
    logic finish;

    assign accept       = in_valid && in_ready && !start;
    assign mismatch     = a_bit ^ b_bit;
    assign next_decided = decided | mismatch;
    assign next_sign    = decided ? sign : a_bit;
    assign finish       = last_beat || (EARLY_EXIT && !decided && mismatch);

    // Beat counter: restarted by every start, advanced by every accepted beat
    bit_counter #(
        .BITS (BITS)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .load       (1'b0),
        .load_value ({W{1'b0}}),
        .enable     (accept),
        .terminal   (last_beat)
    );

    // Control FSM with decision flags and registered results
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            decided  <= 1'b0;
            sign     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Start from any state (re)launches a clean comparison
                state    <= ST_SHIFT;
                in_ready <= 1'b1;
                busy     <= 1'b1;
                eq       <= 1'b0;
                gt       <= 1'b0;
                lt       <= 1'b0;
                decided  <= 1'b0;
                sign     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_SHIFT: begin
                        if (accept) begin
                            decided <= next_decided;
                            sign    <= next_sign;
                            if (finish) begin
                                state    <= ST_DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                eq       <= !next_decided;
                                gt       <= next_decided && next_sign;
                                lt       <= next_decided && !next_sign;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
